adc_frame_reader: RTL and testbench
===================================

Name: adc_frame_reader

Overview:
- SPI-style serial ADC front end that answers the game controller's conversion handshake. The controller sends `adc_start` and `channel` (the player select); this block returns `eoc` and `sample[7:0]`, and the controller uses `sample` as its move speed.
- Sits between the VGA/game controller and the off-board 8-channel, 10-bit SPI ADC. It converts one start request into one full serial frame and presents the result as a level-valid byte.

Parameters:
- CLK_DIV, 50: clk cycles per SCLK half-period (100 MHz -> 1 MHz SCLK); minimum 2.
- CH_A, 3'd0: ADC channel used when `channel`=0.
- CH_B, 3'd1: ADC channel used when `channel`=1.
- CSH_CYC, 100: minimum clk cycles `adc_cs_n` stays high between frames.

Ports:
- clk  in  1  100 MHz system clock.
- reset  in  1  synchronous, active-high reset.
- adc_start  in  1  conversion request; may be held high many cycles; only a rising edge is meaningful.
- channel  in  1  player select; latched at the accepted start edge.
- eoc  out  1  high = idle and `sample` valid; low = conversion in progress.
- sample  out  8  latest result, upper 8 bits of the 10-bit ADC code.
- adc_cs_n  out  1  ADC chip select, active low.
- adc_sclk  out  1  serial clock, idles low.
- adc_mosi  out  1  command bits to the ADC.
- adc_miso  in  1  data from the ADC.

Behaviour:
- Reset values: `eoc`=1 (bootstraps the controller, which only issues a start after seeing `eoc` high), `sample`=0, `adc_cs_n`=1, `adc_sclk`=0, `adc_mosi`=0. The start-edge register clears, all counters clear, state=IDLE.
- Start detection: accepted when state=IDLE, `adc_start`=1, the registered previous `adc_start`=0, and the CSH guard counter has expired. Edges seen in any other state are dropped; they are not queued.
- States:
  - IDLE -> SETUP on an accepted edge. On that same clk edge: `eoc`<=0, `adc_cs_n`<=0, channel latched as ch3 = `channel` ? CH_B : CH_A.
  - SETUP: CLK_DIV cycles with `adc_cs_n` low and `adc_sclk` low; `adc_mosi` presents bit 1; then -> SHIFT.
  - SHIFT: 17 SCLK periods (34 half-periods of CLK_DIV cycles each); `adc_sclk` toggles each half-period, starting with a rise.
    - MOSI sequence for rises 1..5: 1 (start), 1 (single-ended), ch3[2], ch3[1], ch3[0]. MOSI changes only on falling edges; after the 5th it is 0.
    - Rises 6 and 7 (sample period and null bit) are ignored.
    - `adc_miso` is sampled on the clk edge that drives `adc_sclk` 0->1, for rises 8..17, MSB first, into a 10-bit shift register.
    - After the 17th fall -> HOLD.
  - HOLD: CLK_DIV cycles, `adc_sclk` low, `adc_cs_n` low; -> DONE.
  - DONE: one cycle. On its edge: `adc_cs_n`<=1, `sample`<=shift[9:2], `eoc`<=1, CSH guard loaded with CSH_CYC; -> IDLE.
- Latency: `eoc` and `adc_cs_n` rise on the same edge, exactly 36*CLK_DIV+1 clk cycles after the edge on which they fell.
- `sample` holds its value during a conversion; it changes only in DONE.
- Reset asserted mid-frame: the next edge forces reset values (`adc_cs_n` high, `adc_sclk` low, `eoc` high). `sample` clears to 0, and the partial frame is discarded.
- Simultaneous events: an accepted edge on the cycle the guard expires starts the frame. `channel` changes after acceptance have no effect on the current frame.

Optional Feature:
- Macro: ADC_AVG_EN.
- Defined: per-channel 8-bit history registers (reset 0). In DONE, `sample` <= (hist[channel] + new8) >> 1 using a 9-bit sum with truncation, then hist[channel] <= new8. Latency is unchanged.
- Undefined: `sample` = new8 directly; no history registers exist.

Test Plan (CLK_DIV=4, CSH_CYC=8, ADC model returns a per-channel 10-bit code on MISO):
- Reset release, no start -> `eoc`=1, `sample`=0x00, `adc_cs_n`=1, `adc_sclk`=0 held indefinitely.
- `channel`=0, `adc_start` high for 12 cycles, model code 0x2A7 -> MOSI bits 1,1,0,0,0; exactly 17 SCLK rises; `eoc` low for 145 cycles; `sample`=0xA9.
- `channel`=1, code 0x3FF -> MOSI bits 1,1,0,0,1; `sample`=0xFF; `adc_start` held high past DONE does not trigger a second frame.
- Second `adc_start` rising edge at SCLK rise 9 of a frame -> ignored: a single frame, no extra `eoc` fall. A new edge 3 cycles after DONE -> ignored (guard active). A new edge 8 cycles after DONE -> accepted.
- Reset pulsed at SCLK rise 12 -> next cycle `adc_cs_n`=1, `adc_sclk`=0, `eoc`=1, `sample`=0. The next start produces a clean 17-rise frame.
- ADC_AVG_EN defined, ch0 codes 0x100 then 0x300 -> `sample`=0x20 then 0x80 (=(0x40+0xC0)>>1). ch1 history is unaffected.

Source files
------------

// File: rtl/adc_frame_reader.sv
// Serial ADC frame reader: turns one adc_start rising edge into a 17-SCLK frame and returns the upper 8 result bits.
// Optional ADC_AVG_EN: sample becomes the average of the new byte and the previous byte for the same player.
module adc_frame_reader #(
  parameter int         CLK_DIV = 50,
  parameter logic [2:0] CH_A    = 3'd0,
  parameter logic [2:0] CH_B    = 3'd1,
  parameter int         CSH_CYC = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       adc_start,
  input  logic       channel,
  output logic       eoc,
  output logic [7:0] sample,
  output logic       adc_cs_n,
  output logic       adc_sclk,
  output logic       adc_mosi,
  input  logic       adc_miso
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GRD_W = $clog2(CSH_CYC + 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t             state_reg;
  logic [DIV_W-1:0]   div_cnt_reg;
  logic [5:0]         half_cnt_reg;
  logic [3:0]         cmd_reg;
  logic [7:0]         shift_reg;
  logic [GRD_W-1:0]   guard_reg;
  logic               start_prev_reg;

  logic div_end;
  logic guard_ok;
  logic start_ok;

  assign div_end  = (div_cnt_reg == DIV_W'(CLK_DIV - 1));
  // Guard value 1 means it expires on this edge, giving exactly CSH_CYC cycles of cs_n high.
  assign guard_ok = (guard_reg <= GRD_W'(1));
  assign start_ok = adc_start && !start_prev_reg && guard_ok;

`ifdef ADC_AVG_EN
  logic       ch_sel_reg;
  logic [7:0] hist_reg [2];
  logic [8:0] avg_sum;
  assign avg_sum = {1'b0, hist_reg[ch_sel_reg]} + {1'b0, shift_reg};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      div_cnt_reg    <= '0;
      half_cnt_reg   <= '0;
      cmd_reg        <= '0;
      shift_reg      <= '0;
      guard_reg      <= '0;
      start_prev_reg <= 1'b0;
      eoc            <= 1'b1;
      sample         <= 8'h00;
      adc_cs_n       <= 1'b1;
      adc_sclk       <= 1'b0;
      adc_mosi       <= 1'b0;
`ifdef ADC_AVG_EN
      ch_sel_reg     <= 1'b0;
      hist_reg[0]    <= 8'h00;
      hist_reg[1]    <= 8'h00;
`endif
    end else begin
      start_prev_reg <= adc_start;
      if (guard_reg != '0) guard_reg <= guard_reg - 1'b1;

      case (state_reg)
        IDLE: begin
          if (start_ok) begin
            state_reg   <= SETUP;
            eoc         <= 1'b0;
            adc_cs_n    <= 1'b0;
            div_cnt_reg <= '0;
            adc_mosi    <= 1'b1;
            cmd_reg     <= {1'b1, (channel ? CH_B : CH_A)};
`ifdef ADC_AVG_EN
            ch_sel_reg  <= channel;
`endif
          end
        end

        SETUP: begin
          if (div_end) begin
            div_cnt_reg  <= '0;
            half_cnt_reg <= '0;
            adc_sclk     <= 1'b1;
            state_reg    <= SHIFT;
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end
        end

        SHIFT: begin
          if (div_end) begin
            div_cnt_reg <= '0;
            if (adc_sclk) begin
              adc_mosi <= cmd_reg[3];
              cmd_reg  <= {cmd_reg[2:0], 1'b0};
            end
            if (half_cnt_reg == 6'd33) begin
              adc_sclk  <= 1'b0;
              state_reg <= HOLD;
            end else begin
              half_cnt_reg <= half_cnt_reg + 6'd1;
              adc_sclk     <= ~adc_sclk;
              // Rises 8..15 carry result bits 9..2; rises 16-17 hold bits 1:0, which are never used.
              if (!adc_sclk && half_cnt_reg >= 6'd13 && half_cnt_reg <= 6'd27)
                shift_reg <= {shift_reg[6:0], adc_miso};
            end
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end
        end

        HOLD: begin
          if (div_end) begin
            div_cnt_reg <= '0;
            state_reg   <= DONE;
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end
        end

        DONE: begin
          adc_cs_n  <= 1'b1;
          eoc       <= 1'b1;
          guard_reg <= GRD_W'(CSH_CYC);
          state_reg <= IDLE;
`ifdef ADC_AVG_EN
          sample               <= avg_sum[8:1];
          hist_reg[ch_sel_reg] <= shift_reg;
`else
          sample    <= shift_reg;
`endif
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_frame_reader.sv
// Bench for adc_frame_reader: behavioural ADC on MISO, bus monitor, and a per-frame reference model.
module tb_adc_frame_reader;

  localparam int         DIV = 4;
  localparam int         CSH = 8;
  localparam logic [2:0] CHA = 3'd0;
  localparam logic [2:0] CHB = 3'd1;

  logic       clk = 1'b0;
  logic       reset;
  logic       adc_start;
  logic       channel;
  logic       eoc;
  logic [7:0] sample;
  logic       adc_cs_n;
  logic       adc_sclk;
  logic       adc_mosi;
  logic       adc_miso = 1'b0;

  int tests = 0;
  int fails = 0;

  adc_frame_reader #(.CLK_DIV(DIV), .CH_A(CHA), .CH_B(CHB), .CSH_CYC(CSH)) dut (
    .clk(clk), .reset(reset), .adc_start(adc_start), .channel(channel),
    .eoc(eoc), .sample(sample), .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk),
    .adc_mosi(adc_mosi), .adc_miso(adc_miso)
  );

  always #5 clk = ~clk;

  // ADC model: shifts the code out after SCLK falls; junk outside the data window.
  logic [9:0] cur_code = 10'h000;
  int         fall_n = 0;
  always @(negedge adc_sclk or posedge adc_cs_n) begin
    if (adc_cs_n === 1'b1) begin
      fall_n   = 0;
      adc_miso = 1'($urandom);
    end else begin
      fall_n = fall_n + 1;
      if (fall_n + 1 >= 8 && fall_n + 1 <= 17) adc_miso = cur_code[17 - (fall_n + 1)];
      else adc_miso = 1'($urandom);
    end
  end

  // Bus monitor
  int         rise_cnt = 0;
  logic [4:0] mosi_bits = '0;
  int         frames = 0;
  int         low_cnt = 0;
  int         last_low = 0;
  logic       prev_cs = 1'b1, prev_sclk = 1'b0, prev_eoc = 1'b1;
  always @(negedge clk) begin
    if (prev_cs === 1'b1 && adc_cs_n === 1'b0) begin
      rise_cnt  = 0;
      mosi_bits = '0;
    end
    if (prev_sclk === 1'b0 && adc_sclk === 1'b1) begin
      rise_cnt = rise_cnt + 1;
      if (rise_cnt <= 5) mosi_bits = {mosi_bits[3:0], adc_mosi};
    end
    if (prev_eoc === 1'b1 && eoc === 1'b0) begin
      frames  = frames + 1;
      low_cnt = 0;
    end
    if (eoc === 1'b0) low_cnt = low_cnt + 1;
    if (prev_eoc === 1'b0 && eoc === 1'b1) last_low = low_cnt;
    prev_cs   = adc_cs_n;
    prev_sclk = adc_sclk;
    prev_eoc  = eoc;
  end

  // Reference model state
  logic [7:0] exp_sample = 8'h00;
  int         hist [2] = '{0, 0};

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input bit ch, input logic [9:0] code, input int pre_wait,
                           input int hold, input int inject_rise);
    int   f0, cyc, inj_cyc, new8, expv;
    bit   seen_low, injected;
    logic [7:0] prev_exp;
    repeat (pre_wait) step();
    cur_code  = code;
    channel   = ch;
    f0        = frames;
    prev_exp  = exp_sample;
    adc_start = 1'b1;
    cyc = 0; inj_cyc = 0; seen_low = 0; injected = 0;
    while (cyc < 800 && !(seen_low && eoc === 1'b1 && cyc >= hold)) begin
      step();
      cyc++;
      if (eoc === 1'b0) seen_low = 1;
      if (cyc == hold) adc_start = 1'b0;
      if (inject_rise > 0 && !injected && rise_cnt == inject_rise) begin
        adc_start = 1'b1;
        injected  = 1;
        inj_cyc   = cyc;
      end
      if (injected && cyc == inj_cyc + 2) adc_start = 1'b0;
      if (cyc == 30) channel = ~ch;
      if (cyc == 60) check("sample_held_mid_frame", sample, prev_exp);
    end
    adc_start = 1'b0;
    new8 = int'(code) / 4;
`ifdef ADC_AVG_EN
    expv = (hist[ch] + new8) / 2;
    hist[ch] = new8;
`else
    expv = new8;
`endif
    exp_sample = 8'(expv);
    check("frame_completed", {30'd0, seen_low, eoc}, 32'd3);
    check("one_eoc_fall", frames, f0 + 1);
    check("sclk_rises", rise_cnt, 17);
    check("mosi_cmd", mosi_bits, {2'b11, (ch ? CHB : CHA)});
    check("eoc_low_cycles", last_low, 36 * DIV + 1);
    check("sample", sample, exp_sample);
    check("cs_n_idle", adc_cs_n, 1);
    $display("[TB] frame ch=%0d code=%03h sample=%02h rises=%0d mosi=%05b low=%0d",
             ch, code, sample, rise_cnt, mosi_bits, last_low);
  endtask

  task automatic reject_probe(input int wait_n, input int hold_n);
    int f0;
    repeat (wait_n) step();
    f0 = frames;
    adc_start = 1'b1;
    repeat (hold_n) step();
    adc_start = 1'b0;
    check("guard_reject_no_frame", frames, f0);
    check("guard_reject_eoc", eoc, 1);
    $display("[TB] guard probe at %0d cycles after DONE rejected, frames=%0d", wait_n + 1, frames);
  endtask

  initial begin
    int   f0, cyc;
    bit   stable;
    reset = 1'b1; adc_start = 1'b0; channel = 1'b0;
    repeat (3) step();
    check("rst_eoc", eoc, 1);
    check("rst_sample", sample, 0);
    check("rst_cs_n", adc_cs_n, 1);
    check("rst_sclk", adc_sclk, 0);
    check("rst_mosi", adc_mosi, 0);
    reset = 1'b0;
    stable = 1;
    repeat (40) begin
      step();
      if (eoc !== 1'b1 || sample !== 8'h00 || adc_cs_n !== 1'b1 || adc_sclk !== 1'b0) stable = 0;
    end
    check("idle_stable", stable, 1);
    check("idle_no_frame", frames, 0);
    $display("[TB] idle after reset: eoc=%0b sample=%02h cs_n=%0b sclk=%0b", eoc, sample, adc_cs_n, adc_sclk);

    run_frame(1'b0, 10'h2A7, 10, 12, 0);
    run_frame(1'b1, 10'h3FF, 10, 200, 0);
    f0 = frames;
    repeat (20) step();
    check("held_start_no_refire", frames, f0);

    run_frame(1'b0, 10'h155, 10, 3, 9);
    reject_probe(2, 2);
    run_frame(1'b1, 10'h1C3, 3, 3, 0);
    reject_probe(6, 1);
    run_frame(1'b0, 10'h100, 10, 3, 0);
    run_frame(1'b0, 10'h300, 10, 3, 0);
    run_frame(1'b1, 10'h2C0, 10, 3, 0);

    // Reset in the middle of a frame
    repeat (10) step();
    channel = 1'b1; cur_code = 10'h3C5;
    adc_start = 1'b1;
    cyc = 0;
    while (cyc < 400 && rise_cnt != 12) begin
      step();
      cyc++;
      if (cyc == 3) adc_start = 1'b0;
    end
    adc_start = 1'b0;
    check("reached_rise_12", rise_cnt, 12);
    reset = 1'b1;
    step();
    check("midrst_cs_n", adc_cs_n, 1);
    check("midrst_sclk", adc_sclk, 0);
    check("midrst_eoc", eoc, 1);
    check("midrst_sample", sample, 0);
    $display("[TB] mid-frame reset: cs_n=%0b sclk=%0b eoc=%0b sample=%02h", adc_cs_n, adc_sclk, eoc, sample);
    reset = 1'b0;
    exp_sample = 8'h00;
    hist[0] = 0; hist[1] = 0;
    run_frame(1'b1, 10'h0F3, 5, 3, 0);

    for (int i = 0; i < 6; i++)
      run_frame(1'($urandom_range(0, 1)), 10'($urandom), 10, int'($urandom_range(1, 20)), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
